// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file access controller: FSM states, command record, default geometry.
package regfile_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int RF_DEPTH       = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Sole master of a small register file: post-reset init sweep, then a valid/ready
// command port (reads/writes) with read data returned on a valid/ready response port.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int                       DATA_WIDTH   = 8,
    parameter int                       ADDR_WIDTH   = 2,
    parameter int unsigned              READ_LATENCY = 0,
    parameter logic [DATA_WIDTH-1:0]    INIT_VALUE   = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_write_address,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_address,
    input  logic [DATA_WIDTH-1:0] rf_read_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [1:0]            wait_cnt;
    logic                  req_fire;
    logic                  rsp_fire;

    // req_ready is registered from state_next, so it is high exactly while in IDLE.
    assign req_fire = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_INIT:      if (init_cnt == LAST_ADDR) state_next = ST_IDLE;
            ST_IDLE:      if (req_fire && !req_write) state_next = ST_READ_WAIT;
            ST_READ_WAIT: if (wait_cnt == 2'd0) state_next = ST_RESP;
            ST_RESP:      if (rsp_fire) state_next = ST_IDLE;
            default:      state_next = ST_INIT;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_INIT;
            init_cnt         <= '0;
            wait_cnt         <= 2'd0;
            req_ready        <= 1'b0;
            init_done        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_addr         <= '0;
            rsp_rdata        <= '0;
            rf_write_en      <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
            rf_read_address  <= '0;
        end else begin
            state       <= state_next;
            req_ready   <= (state_next == ST_IDLE);
            rf_write_en <= 1'b0;
            if (state_next == ST_IDLE) init_done <= 1'b1;

            case (state)
                ST_INIT: begin
                    rf_write_en      <= 1'b1;
                    rf_write_address <= init_cnt;
                    rf_write_data    <= INIT_VALUE;
                    // Saturate on the last address instead of wrapping back to 0.
                    if (init_cnt != LAST_ADDR) init_cnt <= init_cnt + ADDR_WIDTH'(1);
                end
                ST_IDLE: begin
                    if (req_fire) begin
                        if (req_write) begin
                            rf_write_en      <= 1'b1;
                            rf_write_address <= req_addr;
                            rf_write_data    <= req_wdata;
                        end else begin
                            rf_read_address <= req_addr;
                            rsp_addr        <= req_addr;
                            wait_cnt        <= 2'(READ_LATENCY);
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rsp_rdata <= rf_read_data;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
